// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory request/response bus between fetch stage and imem
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - MIPS fetch stage: PC, imem handshake, instruction register, next-PC select
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_if.master       imem,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [31:0]         branch_offset,
    input  logic                jump,
    input  logic [25:0]         jump_target,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [15:0]         imm16,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_instr_valid;
    logic        r_imem_req;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;

    // Next-PC select: jump overrides branch, branch overrides sequential; all wrap mod 2^32.
    // Shifting the full offset left by two discards bits [31:30], matching the word-offset form.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (jump) begin
            w_next_pc = {w_pc_plus4[31:28], jump_target, 2'b00};
        end else if (branch_taken) begin
            w_next_pc = w_pc_plus4 + (branch_offset << 2);
        end
    end

    // Fetch FSM: IDLE -> REQ (wait for ready, latch word) -> HOLD (until stall released) -> REQ.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC_ALIGNED;
            r_instr       <= 32'h0;
            r_instr_valid <= 1'b0;
            r_imem_req    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state    <= S_REQ;
                    r_imem_req <= 1'b1;
                end
                S_REQ: begin
                    if (imem.imem_ready) begin
                        r_instr       <= imem.imem_rdata;
                        r_instr_valid <= 1'b1;
                        r_imem_req    <= 1'b0;
                        r_state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_pc          <= w_next_pc;
                        r_instr_valid <= 1'b0;
                        r_imem_req    <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_instr_valid <= 1'b0;
                    r_imem_req    <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_imem_req;
    assign imem.imem_addr = r_pc;
    assign instr          = r_instr;
    assign instr_valid    = r_instr_valid;
    assign imm16          = r_instr[15:0];
    assign pc             = r_pc;
    assign pc_plus4       = w_pc_plus4;

endmodule
